// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_D  = 1'b0,
    OWN_IF = 1'b1
  } owner_e;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one fixed-latency SRAM port.
// state   | meaning
// IDLE    | no access in flight; grant a requester and issue to memory this cycle
// WAIT    | access in flight; count down to the read-data cycle and capture it
// RESP    | ack the owner for one cycle; nothing issued
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  input  logic        d_wen,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_e    state, state_n;
  owner_e        owner, owner_n;
  logic [LW-1:0] lat_cnt, lat_n;
  logic [SW-1:0] starve_cnt, starve_n;
  logic          grant_if;
  logic          capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_D;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      lat_cnt    <= lat_n;
      starve_cnt <= starve_n;
      if (capture && owner == OWN_IF) if_rdata <= mem_rdata;
      if (capture && owner == OWN_D)  d_rdata  <= mem_rdata;
    end
  end

  // Issue is combinational in IDLE so the grant cycle is the request cycle;
  // gated by rst so nothing reaches memory while reset is held.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    lat_n     = lat_cnt;
    starve_n  = starve_cnt;
    grant_if  = 1'b0;
    capture   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_wen   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!if_req) starve_n = '0;
        if (!rst && (if_req || d_req)) begin
          grant_if = if_req && (!d_req || starve_cnt == STARVE_TOP);
          mem_req  = 1'b1;
          lat_n    = LAT_INIT;
          state_n  = ST_WAIT;
          if (grant_if) begin
            mem_addr = if_addr;
            owner_n  = OWN_IF;
            starve_n = '0;
          end else begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wen   = d_wen;
            mem_wmask = d_wen ? d_wmask : 4'b0000;
            owner_n   = OWN_D;
            if (if_req && starve_cnt != STARVE_TOP) starve_n = starve_cnt + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt == '0) begin
          capture = 1'b1;
          state_n = ST_RESP;
        end else begin
          lat_n = lat_cnt - 1'b1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign if_ack   = (state == ST_RESP) && (owner == OWN_IF);
  assign d_ack    = (state == ST_RESP) && (owner == OWN_D);
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  // Requesters own their request until acked.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_ack) |=> (if_req && $stable(if_addr)));
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (d_req && !d_ack) |=> (d_req && $stable(d_addr) && $stable(d_wdata)
                           && $stable(d_wmask) && $stable(d_wen)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: ack scoreboard plus issue-cycle checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wmask = '0;
  logic        d_wen = 1'b0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask), .d_wen(d_wen),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid exactly two cycles after the issue strobe.
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0;
  always @(posedge clk) begin
    v1 <= v0;
    a1 <= a0;
    v0 <= mem_req;
    a0 <= mem_addr;
  end
  assign mem_rdata = v1 ? (a1 ^ 32'hA5A5_0000) : 32'h5A5A_5A5A;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   t0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && (if_ack || d_ack)) begin
      if (if_ack && d_ack) chk("dual_ack", 32'd1, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("ack_port", 32'(if_ack), 32'(e.is_if));
        chk("ack_rdata", if_ack ? if_rdata : d_rdata, e.rdata);
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_if);
    int n = 0;
    forever begin
      @(negedge clk);
      if (is_if ? if_ack : d_ack) break;
      n++;
      if (n > 20) begin
        chk("ack_timeout", 32'(is_if), 32'hFFFF_FFFF);
        break;
      end
    end
    tick();
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_if_ack", 32'(if_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_if_stall", 32'(if_stall), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: lone fetch
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    q.push_back('{1'b1, 32'hA5A5_0100, t0 + 3});
    @(negedge clk);
    chk("t1_mem_req", 32'(mem_req), 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_wen", 32'(mem_wen), 0);
    chk("t1_stall0", 32'(if_stall), 1);
    for (int k = 1; k <= 2; k++) begin
      tick(); @(negedge clk);
      chk("t1_stall", 32'(if_stall), 1);
      chk("t1_mem_idle", 32'(mem_req), 0);
    end
    tick(); @(negedge clk);
    chk("t1_ack", 32'(if_ack), 1);
    chk("t1_stall_ack", 32'(if_stall), 0);
    tick();
    if_req = 1'b0;

    // 2: simultaneous fetch and load, data wins
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_addr = 32'h200; d_wen = 1'b0;
    q.push_back('{1'b0, 32'hA5A5_0200, t0 + 3});
    q.push_back('{1'b1, 32'hA5A5_0104, t0 + 7});
    @(negedge clk);
    chk("t2_data_first", mem_addr, 32'h200);
    wait_ack(1'b0);
    d_req = 1'b0;
    @(negedge clk);
    chk("t2_fetch_issue", 32'(mem_req), 1);
    chk("t2_fetch_addr", mem_addr, 32'h104);
    chk("t2_fetch_cyc", 32'(cyc), 32'(t0 + 4));
    wait_ack(1'b1);
    if_req = 1'b0;

    // 3: starvation guard
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h108;
    d_req = 1'b1; d_addr = 32'h300;
    q.push_back('{1'b0, 32'hA5A5_0300, t0 + 3});
    q.push_back('{1'b0, 32'hA5A5_0304, t0 + 7});
    q.push_back('{1'b0, 32'hA5A5_0308, t0 + 11});
    q.push_back('{1'b1, 32'hA5A5_0108, t0 + 15});
    q.push_back('{1'b0, 32'hA5A5_030C, t0 + 19});
    wait_ack(1'b0); d_addr = 32'h304;
    wait_ack(1'b0); d_addr = 32'h308;
    wait_ack(1'b0); d_addr = 32'h30C;
    @(negedge clk);
    chk("t3_forced_fetch", mem_addr, 32'h108);
    wait_ack(1'b1);
    if_req = 1'b0;
    wait_ack(1'b0);
    d_req = 1'b0;
    chk("t3_starve_clr", 32'(dut.starve_cnt), 0);

    // 4: store
    t0 = cyc;
    d_req = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011; d_wen = 1'b1;
    q.push_back('{1'b0, 32'hA5A5_0040, t0 + 3});
    @(negedge clk);
    chk("t4_wen", 32'(mem_wen), 1);
    chk("t4_wmask", 32'(mem_wmask), 32'h3);
    chk("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t4_addr", mem_addr, 32'h40);
    tick(); @(negedge clk);
    chk("t4_post_req", 32'(mem_req), 0);
    chk("t4_post_wen", 32'(mem_wen), 0);
    chk("t4_post_wmask", 32'(mem_wmask), 0);
    chk("t4_post_addr", mem_addr, 0);
    chk("t4_post_wdata", mem_wdata, 0);
    wait_ack(1'b0);
    d_req = 1'b0; d_wen = 1'b0; d_wmask = 4'b0000; d_wdata = '0;

    // 6: lone load held through RESP; mask forced to 0 on loads
    t0 = cyc;
    d_req = 1'b1; d_addr = 32'h500; d_wmask = 4'hF;
    q.push_back('{1'b0, 32'hA5A5_0500, t0 + 3});
    @(negedge clk);
    chk("t6_issue", 32'(mem_req), 1);
    chk("t6_load_wmask", 32'(mem_wmask), 0);
    for (int k = 1; k <= 3; k++) begin
      tick(); @(negedge clk);
      chk("t6_no_regrant", 32'(mem_req), 0);
    end
    tick();
    d_req = 1'b0; d_wmask = 4'h0;
    @(negedge clk);
    chk("t6_if_rdata_held", if_rdata, 32'hA5A5_0108);

    // 5: reset during an in-flight fetch
    tick();
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h600;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_if_ack", 32'(if_ack), 0);
    chk("t5_d_ack", 32'(d_ack), 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_d_rdata", d_rdata, 0);
    chk("t5_mem_req", 32'(mem_req), 0);
    chk("t5_mem_wen", 32'(mem_wen), 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_state", 32'(dut.state), 0);
    tick();
    rst = 1'b0;
    q.push_back('{1'b1, 32'hA5A5_0600, t0 + 6});
    @(negedge clk);
    chk("t5_reissue", 32'(mem_req), 1);
    chk("t5_reissue_addr", mem_addr, 32'h600);
    wait_ack(1'b1);
    if_req = 1'b0;

    repeat (5) tick();
    chk("scoreboard_drain", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout actual=%0d required=<20000ns", cyc);
    $fatal(1);
  end

endmodule
